// File: rtl/frame_buf_arbiter_pkg.sv
// Shared definitions for the SDRAM frame-buffer arbiter: defaults, write-FSM
// state encoding and the per-channel region address helpers.
package frame_buf_pkg;

   localparam int unsigned ADDR_W_DEF      = 24;
   localparam int unsigned LCD_H_PIX       = 800;
   localparam int unsigned LCD_V_PIX       = 480;
   localparam int unsigned FRAME_WORDS_DEF = LCD_H_PIX * LCD_V_PIX;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_ARB   = 2'd1,
      WR_WRITE = 2'd2
   } wr_state_e;

   // Width of a channel index; at least one bit even for a single channel.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First word of frame region k.
   function automatic logic [63:0] region_base(input int unsigned k,
                                               input logic [63:0] base,
                                               input logic [63:0] words);
      return base + 64'(k) * words;
   endfunction

endpackage

// File: rtl/frame_buf_arbiter_if.sv
// Producer/LCD-facing bus of the frame-buffer arbiter. The master side is the
// processing pipeline and LCD timing logic; the slave side is the arbiter.
interface frame_buf_arbiter_if
   import frame_buf_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   localparam int unsigned CH_W = ch_width(NUM_CH);

   logic              shot_done;
   logic [NUM_CH-1:0] wr_req;
   logic [NUM_CH-1:0] wr_last;
   logic              lcd_rd_en;
   logic [CH_W-1:0]   disp_sel;

   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [ADDR_W-1:0] wr_min_addr;
   logic [ADDR_W-1:0] wr_max_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_min_addr;
   logic [ADDR_W-1:0] rd_max_addr;
   logic [NUM_CH-1:0] frame_done;
   logic              lcd_rst_n;

   modport master (
      output shot_done, wr_req, wr_last, lcd_rd_en, disp_sel,
      input  wr_en, wr_ch, wr_min_addr, wr_max_addr,
      input  rd_en, rd_min_addr, rd_max_addr, frame_done, lcd_rst_n
   );

   modport slave (
      input  shot_done, wr_req, wr_last, lcd_rd_en, disp_sel,
      output wr_en, wr_ch, wr_min_addr, wr_max_addr,
      output rd_en, rd_min_addr, rd_max_addr, frame_done, lcd_rst_n
   );

endinterface

// File: rtl/frame_buf_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above
// rr_ptr, wrapping past the highest channel back to channel 0.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CH_W   = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   rr_ptr,
   output logic [NUM_CH-1:0] gnt_oh,
   output logic [CH_W-1:0]   gnt_idx
);

   logic            found;
   logic [CH_W:0]   wrap_sum;
   logic [CH_W-1:0] cand;

   // Scan NUM_CH candidates starting at rr_ptr; the extra sum bit catches wrap.
   always_comb begin
      gnt_oh   = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      wrap_sum = '0;
      cand     = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wrap_sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
         if (32'(wrap_sum) >= NUM_CH) begin
            wrap_sum = wrap_sum - (CH_W+1)'(NUM_CH);
         end
         cand = wrap_sum[CH_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            gnt_oh[cand] = 1'b1;
            gnt_idx     = cand;
         end
      end
   end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Frame-buffer arbiter: round-robin frame-length write grants with fixed
// per-channel SDRAM windows, plus LCD read gating on a completed region.
module frame_buf_arbiter
   import frame_buf_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int unsigned BASE_ADDR   = 0
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   frame_buf_arbiter_if.slave bus
);

   localparam int unsigned CH_W = ch_width(NUM_CH);
   localparam int unsigned NSEL = 1 << CH_W;

   // Elaboration-time region windows and the set of selectable channels.
   logic [ADDR_W-1:0] region_min [NUM_CH];
   logic [ADDR_W-1:0] region_max [NUM_CH];
   logic [NSEL-1:0]   sel_ok;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_region
      assign region_min[k] = ADDR_W'(region_base(k, 64'(BASE_ADDR), 64'(FRAME_WORDS)));
      assign region_max[k] = ADDR_W'(region_base(k, 64'(BASE_ADDR), 64'(FRAME_WORDS))
                                     + 64'(FRAME_WORDS) - 64'd1);
   end

   for (genvar s = 0; s < NSEL; s++) begin : g_sel_ok
      assign sel_ok[s] = (s < NUM_CH);
   end

   wr_state_e         state_q, state_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0] frame_valid_q, frame_valid_d;
   logic [CH_W-1:0]   sel_q, sel_d;
   logic              wr_en_q, wr_en_d;
   logic [CH_W-1:0]   wr_ch_q, wr_ch_d;
   logic [ADDR_W-1:0] wr_min_q, wr_min_d;
   logic [ADDR_W-1:0] wr_max_q, wr_max_d;
   logic [NUM_CH-1:0] frame_done_q, frame_done_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_min_q, rd_min_d;
   logic [ADDR_W-1:0] rd_max_q, rd_max_d;
   logic              lcd_rst_n_q, lcd_rst_n_d;

   logic [NUM_CH-1:0] gnt_oh;
   logic [CH_W-1:0]   gnt_idx;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_arbiter (
      .req     (bus.wr_req),
      .rr_ptr  (rr_ptr_q),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx)
   );

   // Next-state logic for the write FSM and the read-side gating.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      frame_valid_d = frame_valid_q;
      wr_en_d       = wr_en_q;
      wr_ch_d       = wr_ch_q;
      wr_min_d      = wr_min_q;
      wr_max_d      = wr_max_q;
      frame_done_d  = '0;

      unique case (state_q)
         WR_IDLE: begin
            if (bus.shot_done) begin
               state_d = WR_ARB;
            end
         end
         WR_ARB: begin
            if (|gnt_oh) begin
               wr_ch_d  = gnt_idx;
               wr_min_d = region_min[gnt_idx];
               wr_max_d = region_max[gnt_idx];
               wr_en_d  = 1'b1;
               state_d  = WR_WRITE;
            end
         end
         WR_WRITE: begin
            if (bus.wr_last[wr_ch_q]) begin
               wr_en_d                = 1'b0;
               state_d                = WR_ARB;
               rr_ptr_d               = (32'(wr_ch_q) == NUM_CH - 1) ? '0 : wr_ch_q + CH_W'(1);
               frame_valid_d[wr_ch_q] = 1'b1;
               frame_done_d[wr_ch_q]  = 1'b1;
            end
         end
         default: begin
            state_d = WR_IDLE;
            wr_en_d = 1'b0;
         end
      endcase

      // The displayed region only moves between LCD frames.
      sel_d = sel_q;
      if (!bus.lcd_rd_en && sel_ok[bus.disp_sel]) begin
         sel_d = bus.disp_sel;
      end
      rd_min_d    = region_min[sel_q];
      rd_max_d    = region_max[sel_q];
      lcd_rst_n_d = lcd_rst_n_q | frame_valid_q[sel_q];
      rd_en_d     = bus.lcd_rd_en & lcd_rst_n_q;
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= WR_IDLE;
         rr_ptr_q      <= '0;
         frame_valid_q <= '0;
         sel_q         <= '0;
         wr_en_q       <= 1'b0;
         wr_ch_q       <= '0;
         wr_min_q      <= '0;
         wr_max_q      <= '0;
         frame_done_q  <= '0;
         rd_en_q       <= 1'b0;
         rd_min_q      <= '0;
         rd_max_q      <= '0;
         lcd_rst_n_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         frame_valid_q <= frame_valid_d;
         sel_q         <= sel_d;
         wr_en_q       <= wr_en_d;
         wr_ch_q       <= wr_ch_d;
         wr_min_q      <= wr_min_d;
         wr_max_q      <= wr_max_d;
         frame_done_q  <= frame_done_d;
         rd_en_q       <= rd_en_d;
         rd_min_q      <= rd_min_d;
         rd_max_q      <= rd_max_d;
         lcd_rst_n_q   <= lcd_rst_n_d;
      end
   end

   assign bus.wr_en       = wr_en_q;
   assign bus.wr_ch       = wr_ch_q;
   assign bus.wr_min_addr = wr_min_q;
   assign bus.wr_max_addr = wr_max_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.rd_en       = rd_en_q;
   assign bus.rd_min_addr = rd_min_q;
   assign bus.rd_max_addr = rd_max_q;
   assign bus.lcd_rst_n   = lcd_rst_n_q;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter: directed stimulus with a grant/frame_done
// scoreboard drained by an independent monitor.
module tb_frame_buf_arbiter;

   logic sys_clk;
   logic sys_rst_n;

   frame_buf_arbiter_if #(.NUM_CH(2), .ADDR_W(24)) bus ();
   frame_buf_arbiter_if #(.NUM_CH(3), .ADDR_W(24)) bus3 ();

   frame_buf_arbiter #(
      .NUM_CH      (2),
      .ADDR_W      (24),
      .FRAME_WORDS (384000),
      .BASE_ADDR   (0)
   ) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   frame_buf_arbiter #(
      .NUM_CH      (3),
      .ADDR_W      (24),
      .FRAME_WORDS (384000),
      .BASE_ADDR   (0)
   ) u_dut3 (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus3)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   typedef struct {
      logic [0:0]  ch;
      logic [23:0] mn;
      logic [23:0] mx;
      int          gap;
   } grant_t;

   grant_t     gq[$];
   logic [1:0] dq[$];
   int         n_chk = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_grant(input logic [0:0] ch, input int gap);
      grant_t g;
      g.ch  = ch;
      g.mn  = (ch == 1'b0) ? 24'd0 : 24'd384000;
      g.mx  = (ch == 1'b0) ? 24'd383999 : 24'd767999;
      g.gap = gap;
      gq.push_back(g);
   endtask

   task automatic check_zero(input string name);
      check(name, {bus.wr_en, bus.wr_ch, bus.wr_min_addr, bus.wr_max_addr, bus.rd_en,
                   bus.rd_min_addr, bus.rd_max_addr, bus.frame_done, bus.lcd_rst_n}, 128'd0);
   endtask

   // Monitor: pop the expected grant on each wr_en rise, the expected pulse on each frame_done.
   grant_t cur;
   logic   prev_we = 1'b0;
   int     low_cnt = 0;
   bit     have_fall = 1'b0;

   always @(negedge sys_clk) begin
      if (!mon_en) begin
         prev_we   = 1'b0;
         low_cnt   = 0;
         have_fall = 1'b0;
      end else begin
         if (bus.wr_en && !prev_we) begin
            if (gq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL grant_unexpected: wr_ch=%0d granted, none expected", bus.wr_ch);
            end else begin
               cur = gq.pop_front();
               check("grant_window", {bus.wr_ch, bus.wr_min_addr, bus.wr_max_addr},
                     {cur.ch, cur.mn, cur.mx});
               if (cur.gap >= 0) check("grant_gap", 128'(low_cnt), 128'(cur.gap));
            end
            have_fall = 1'b0;
         end else if (bus.wr_en) begin
            check("addr_stable", {bus.wr_ch, bus.wr_min_addr, bus.wr_max_addr},
                  {cur.ch, cur.mn, cur.mx});
         end else if (prev_we) begin
            low_cnt   = 1;
            have_fall = 1'b1;
         end else if (have_fall) begin
            low_cnt++;
         end
         if (bus.frame_done != 2'b00) begin
            if (dq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL done_unexpected: frame_done=%b, none expected", bus.frame_done);
            end else begin
               check("frame_done", 128'(bus.frame_done), 128'(dq.pop_front()));
               check("done_at_fall", {bus.wr_en, prev_we}, 128'b01);
            end
         end
         prev_we = bus.wr_en;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      bit ever;
      sys_rst_n      = 1'b0;
      bus.shot_done  = 1'b0;
      bus.wr_req     = '0;
      bus.wr_last    = '0;
      bus.lcd_rd_en  = 1'b0;
      bus.disp_sel   = '0;
      bus3.shot_done = 1'b0;
      bus3.wr_req    = '0;
      bus3.wr_last   = '0;
      bus3.lcd_rd_en = 1'b0;
      bus3.disp_sel  = '0;
      repeat (3) tick();
      check_zero("reset_outputs");
      sys_rst_n = 1'b1;
      mon_en    = 1'b1;

      // Three-channel instance: region 2 window, then an out-of-range select.
      bus3.disp_sel = 2'd2;
      bus.disp_sel  = 1'b1;
      tick();
      tick();
      check("rd_win3_ch2", {bus3.rd_min_addr, bus3.rd_max_addr}, {24'd768000, 24'd1151999});
      bus3.disp_sel = 2'd3;
      repeat (3) tick();
      check("rd_win3_sel3_ignored", {bus3.rd_min_addr, bus3.rd_max_addr}, {24'd768000, 24'd1151999});

      // Requests without shot_done are not granted.
      bus.wr_req = 2'b11;
      ever = 1'b0;
      repeat (100) begin
         tick();
         if (bus.wr_en) ever = 1'b1;
      end
      check("no_grant_before_shot", 128'(ever), 128'd0);

      // shot_done -> ARB -> grant ch0 two edges later.
      push_grant(1'b0, -1);
      bus.shot_done = 1'b1;
      tick();
      bus.shot_done = 1'b0;
      check("grant_lat_edge1", 128'(bus.wr_en), 128'd0);
      tick();
      check("grant_lat_edge2", 128'(bus.wr_en), 128'd1);
      bus.lcd_rd_en = 1'b1;

      // wr_last on the non-granted channel is ignored.
      bus.wr_last = 2'b10;
      tick();
      bus.wr_last = 2'b00;
      repeat (3) tick();
      check("ch1_last_ignored", 128'(bus.wr_en), 128'd1);
      check("rd_blocked", {bus.lcd_rst_n, bus.rd_en}, 128'b00);
      check("rd_win_ch1", {bus.rd_min_addr, bus.rd_max_addr}, {24'd384000, 24'd767999});

      // Release ch0, ch1 granted after one low cycle.
      dq.push_back(2'b01);
      push_grant(1'b1, 1);
      bus.wr_last = 2'b01;
      tick();
      bus.wr_last = 2'b00;
      check("release_ch0", 128'(bus.wr_en), 128'd0);
      tick();
      check("regrant_ch1", 128'(bus.wr_en), 128'd1);
      repeat (4) tick();

      // Release ch1: frame_valid[1] then lcd_rst_n then rd_en.
      dq.push_back(2'b10);
      push_grant(1'b0, 1);
      bus.wr_last = 2'b10;
      tick();
      bus.wr_last = 2'b00;
      check("lcd_rst_edge1", 128'(bus.lcd_rst_n), 128'd0);
      tick();
      check("lcd_rst_edge2", {bus.lcd_rst_n, bus.rd_en}, 128'b10);
      tick();
      check("rd_en_on", 128'(bus.rd_en), 128'd1);

      // Select changes are held off while the LCD is reading.
      bus.disp_sel = 1'b0;
      repeat (3) tick();
      check("rd_win_hold", {bus.rd_min_addr, bus.rd_max_addr}, {24'd384000, 24'd767999});
      bus.lcd_rd_en = 1'b0;
      tick();
      check("rd_en_off", 128'(bus.rd_en), 128'd0);
      tick();
      check("rd_win_ch0", {bus.rd_min_addr, bus.rd_max_addr}, {24'd0, 24'd383999});
      check("lcd_rst_sticky", 128'(bus.lcd_rst_n), 128'd1);

      // Release ch0 again, then reset in the middle of the ch1 frame.
      dq.push_back(2'b01);
      push_grant(1'b1, 1);
      bus.wr_last = 2'b01;
      tick();
      bus.wr_last = 2'b00;
      repeat (4) tick();
      check("midframe_busy", {bus.wr_en, bus.wr_ch}, 128'b11);
      mon_en    = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      check_zero("async_reset_outputs");
      tick();
      gq.delete();
      dq.delete();
      sys_rst_n = 1'b1;
      mon_en    = 1'b1;

      // After reset a fresh shot_done is required; rr_ptr restarts at ch0.
      ever = 1'b0;
      repeat (10) begin
         tick();
         if (bus.wr_en) ever = 1'b1;
      end
      check("no_grant_after_reset", 128'(ever), 128'd0);
      check("lcd_rst_cleared", 128'(bus.lcd_rst_n), 128'd0);
      push_grant(1'b0, -1);
      bus.shot_done = 1'b1;
      tick();
      bus.shot_done = 1'b0;
      tick();
      check("regrant_after_reset", {bus.wr_en, bus.wr_ch}, 128'b10);
      repeat (2) tick();
      dq.push_back(2'b01);
      bus.wr_req  = 2'b00;
      bus.wr_last = 2'b01;
      tick();
      bus.wr_last = 2'b00;
      repeat (3) tick();

      check("grants_drained", 128'(gq.size()), 128'd0);
      check("dones_drained", 128'(dq.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
